// File: rtl/vx_credit_arb_pkg.sv
// vx_credit_arb_pkg
//   Shared helpers for the credit arbiter and its per-requester credit counter:
//   derived tag/credit widths and a parameter sanity check.
package vx_credit_arb_pkg;

  // Width of a requester-index tag; never narrower than one bit so that a
  // single-requester build still has a real tag port.
  function automatic int tag_width(input int num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

  // Width needed to hold the values 0..max_credits inclusive.
  function automatic int credit_width(input int max_credits);
    return $clog2(max_credits + 1);
  endfunction

  function automatic bit params_ok(input int num_reqs, input int max_credits);
    return (num_reqs >= 1) && (max_credits >= 1);
  endfunction

endpackage

// File: rtl/vx_credit_counter.sv
// vx_credit_counter
//   Saturating credit counter for one requester. Starts full (MAX_CREDITS)
//   out of reset, counts down on consume, up on release_in. A consume and a
//   release in the same cycle cancel. A release while already full is dropped
//   and flagged on overflow_err so the parent can report it.
// Ports:
//   clk, reset    clock, synchronous active-high reset (reloads MAX_CREDITS)
//   consume       one credit spent this cycle (only issued while nonzero)
//   release_in    one credit returned this cycle
//   nonzero       count != 0
//   overflow_err  release_in hit a full counter this cycle (combinational)
module vx_credit_counter
  import vx_credit_arb_pkg::*;
#(
  parameter  int MAX_CREDITS = 4,
  localparam int CREDITW     = credit_width(MAX_CREDITS)
) (
  input  logic clk,
  input  logic reset,
  input  logic consume,
  input  logic release_in,
  output logic nonzero,
  output logic overflow_err
);

  localparam logic [CREDITW-1:0] FULL = CREDITW'(MAX_CREDITS);
  localparam logic [CREDITW-1:0] ONE  = CREDITW'(1);

  logic [CREDITW-1:0] count_q, count_d;

  always_comb begin
    count_d      = count_q;
    overflow_err = 1'b0;
    if (consume && !release_in) begin
      if (count_q != '0) count_d = count_q - ONE;
    end else if (release_in && !consume) begin
      if (count_q == FULL) overflow_err = 1'b1;
      else                 count_d      = count_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= FULL;
    else       count_q <= count_d;
  end

  assign nonzero = (count_q != '0);

endmodule

// File: rtl/vx_credit_arbiter.sv
// vx_credit_arbiter
//   Shares one downstream stream port among NUM_REQS requesters. Each
//   requester holds up to MAX_CREDITS credits; a grant spends one and the
//   downstream response path returns them via credit_valid/credit_tag.
//   Round-robin among requesters that are valid and hold a credit; the winner
//   is captured in a one-deep output register together with its index (tag).
//
//   Handshake: a transfer on either side happens in a cycle where valid and
//   ready are both high. Requesters hold valid_in/data_in until ready_in (they
//   may drop valid_in early and simply lose eligibility). ready_in never
//   depends on ready_in; valid_out never depends on ready_out.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   valid_in/data_in/ready_in  per-requester request channel
//   valid_out/data_out/tag_out registered downstream beat, tag = requester
//   ready_out                  downstream accept
//   credit_valid/credit_tag    one credit returned to requester credit_tag
//   credit_avail               per-requester "has at least one credit"
//   perf_stall_credit/out      64-bit stall counters, only present when the
//                              VX_CREDIT_ARB_PERF_EN macro is defined
module vx_credit_arbiter
  import vx_credit_arb_pkg::*;
#(
  parameter  int NUM_REQS    = 4,
  parameter  int DATAW       = 32,
  parameter  int MAX_CREDITS = 4,
  localparam int TAGW        = tag_width(NUM_REQS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       valid_in,
  input  logic [NUM_REQS*DATAW-1:0] data_in,
  output logic [NUM_REQS-1:0]       ready_in,
  output logic                      valid_out,
  output logic [DATAW-1:0]          data_out,
  output logic [TAGW-1:0]           tag_out,
  input  logic                      ready_out,
  input  logic                      credit_valid,
  input  logic [TAGW-1:0]           credit_tag,
  output logic [NUM_REQS-1:0]       credit_avail
`ifdef VX_CREDIT_ARB_PERF_EN
  ,
  output logic [63:0]               perf_stall_credit,
  output logic [63:0]               perf_stall_out
`endif
);

  if (!params_ok(NUM_REQS, MAX_CREDITS)) begin : g_param_check
    $error("vx_credit_arbiter: NUM_REQS and MAX_CREDITS must both be >= 1");
  end

  logic [NUM_REQS-1:0] avail, elig, grant_onehot, tag_hit, ovf_err;
  logic [TAGW-1:0]     grant_idx;
  logic [DATAW-1:0]    grant_data;
  logic                stage_ready, accept;
  int                  scan_idx;

  logic                last_valid_unused;
  logic [TAGW-1:0]     last_grant_q, last_grant_d;
  logic                valid_q, valid_d;
  logic [DATAW-1:0]    data_q, data_d;
  logic [TAGW-1:0]     tag_q, tag_d;

  assign last_valid_unused = 1'b0;

  // Per-requester credit counters. A credit_tag outside 0..NUM_REQS-1 hits
  // no counter, so it is dropped here and reported below.
  for (genvar i = 0; i < NUM_REQS; i++) begin : g_credit
    assign tag_hit[i] = (credit_tag == TAGW'(i));
    vx_credit_counter #(.MAX_CREDITS(MAX_CREDITS)) u_cnt (
      .clk          (clk),
      .reset        (reset),
      .consume      (ready_in[i]),
      .release_in   (credit_valid && tag_hit[i]),
      .nonzero      (avail[i]),
      .overflow_err (ovf_err[i])
    );
  end

  assign elig         = valid_in & avail;
  assign credit_avail = avail;

  // Round-robin: scan from the index after the last winner, wrapping, and
  // take the first eligible requester.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    grant_data   = '0;
    scan_idx     = 0;
    for (int off = 1; off <= NUM_REQS; off++) begin
      scan_idx = (int'(last_grant_q) + off) % NUM_REQS;
      if ((grant_onehot == '0) && elig[scan_idx]) begin
        grant_onehot[scan_idx] = 1'b1;
        grant_idx              = TAGW'(scan_idx);
        grant_data             = data_in[scan_idx*DATAW +: DATAW];
      end
    end
  end

  assign stage_ready = !valid_q || ready_out;
  assign accept      = (grant_onehot != '0) && stage_ready && !reset;
  assign ready_in    = grant_onehot & {NUM_REQS{stage_ready && !reset}};

  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    tag_d        = tag_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      valid_d      = 1'b1;
      data_d       = grant_data;
      tag_d        = grant_idx;
      last_grant_d = grant_idx;
    end else if (ready_out) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      tag_q        <= '0;
      last_grant_q <= TAGW'(NUM_REQS - 1);
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      tag_q        <= tag_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign tag_out   = tag_q;

  // Illegal credit returns are dropped by the counters; flag them in simulation.
  always_ff @(posedge clk) begin
    if (!reset && credit_valid) begin
      assert (tag_hit != '0)
        else $warning("vx_credit_arbiter: credit_tag %0d out of range, return dropped", credit_tag);
      assert (ovf_err == '0)
        else $warning("vx_credit_arbiter: credit return to full requester %0d dropped", credit_tag);
    end
  end

`ifdef VX_CREDIT_ARB_PERF_EN
  logic [63:0] perf_stall_credit_q, perf_stall_credit_d;
  logic [63:0] perf_stall_out_q, perf_stall_out_d;

  // Credit stall: someone wants to go but every valid requester is out of credits.
  always_comb begin
    perf_stall_credit_d = perf_stall_credit_q + 64'((valid_in != '0) && (elig == '0));
    perf_stall_out_d    = perf_stall_out_q + 64'(valid_q && !ready_out);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_credit_q <= '0;
      perf_stall_out_q    <= '0;
    end else begin
      perf_stall_credit_q <= perf_stall_credit_d;
      perf_stall_out_q    <= perf_stall_out_d;
    end
  end

  assign perf_stall_credit = perf_stall_credit_q;
  assign perf_stall_out    = perf_stall_out_q;
`endif

endmodule
